// File: rtl/line_scan.sv
// Snapshots a parallel obstacle line and streams it one column per pixel strobe,
// tracking the longest open (0) run as it goes.
module line_scan #(
    parameter int WIDTH = 640,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] line_i,
    input  logic             req_i,
    input  logic             pix_en_i,
    output logic             ack_o,
    output logic             busy_o,
    output logic             pix_o,
    output logic             pix_valid_o,
    output logic [CW-1:0]    col_o,
    output logic             done_o,
    output logic [CW-1:0]    gap_start_o,
    output logic [CW-1:0]    gap_len_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    col;
    logic [CW-1:0]    cur_len, cur_start, best_len, best_start;

    logic             capture, consume, last, bit_now, new_best;
    logic [CW-1:0]    run_len, run_start, fin_len, fin_start;

    assign capture = (state == IDLE) && req_i;
    assign consume = (state == SCAN) && pix_en_i;
    assign last    = consume && (col == CW'(WIDTH - 1));
    assign bit_now = shadow[col];

    // Best is resolved combinationally so a run that ends on the final
    // column is already included in the values latched at done.
    assign run_len   = cur_len + CW'(1);
    assign run_start = (cur_len == '0) ? col : cur_start;
    assign new_best  = !bit_now && (run_len > best_len);
    assign fin_len   = new_best ? run_len : best_len;
    assign fin_start = new_best ? run_start : best_start;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shadow      <= '1;
            col         <= '0;
            cur_len     <= '0;
            cur_start   <= '0;
            best_len    <= '0;
            best_start  <= '0;
            ack_o       <= 1'b0;
            busy_o      <= 1'b0;
            pix_o       <= 1'b0;
            pix_valid_o <= 1'b0;
            col_o       <= '0;
            done_o      <= 1'b0;
            gap_start_o <= '0;
            gap_len_o   <= '0;
        end else begin
            ack_o       <= 1'b0;
            done_o      <= 1'b0;
            pix_valid_o <= 1'b0;
            if (capture) begin
                shadow     <= line_i;
                col        <= '0;
                cur_len    <= '0;
                cur_start  <= '0;
                best_len   <= '0;
                best_start <= '0;
                ack_o      <= 1'b1;
                busy_o     <= 1'b1;
            end
            if (consume) begin
                pix_o       <= bit_now;
                col_o       <= col;
                pix_valid_o <= 1'b1;
                col         <= col + CW'(1);
                if (bit_now) begin
                    cur_len <= '0;
                end else begin
                    cur_len   <= run_len;
                    cur_start <= run_start;
                end
                best_len   <= fin_len;
                best_start <= fin_start;
                if (last) begin
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    gap_len_o   <= fin_len;
                    gap_start_o <= (fin_len == '0) ? '0 : fin_start;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_scan.sv
// Directed bench for line_scan: streaming, gap search, stalls, isolation,
// async reset mid-scan and back-to-back captures.
module tb_line_scan;

    localparam int WIDTH = 640;
    localparam int CW    = 10;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [WIDTH-1:0] line_i;
    logic             req_i, pix_en_i;
    logic             ack_o, busy_o, pix_o, pix_valid_o, done_o;
    logic [CW-1:0]    col_o, gap_start_o, gap_len_o;

    int checks = 0;
    int passed = 0;

    line_scan #(.WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .line_i(line_i), .req_i(req_i),
        .pix_en_i(pix_en_i), .ack_o(ack_o), .busy_o(busy_o), .pix_o(pix_o),
        .pix_valid_o(pix_valid_o), .col_o(col_o), .done_o(done_o),
        .gap_start_o(gap_start_o), .gap_len_o(gap_len_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] zeros(input int lo, input int hi, input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] l;
        l = base;
        for (int i = lo; i <= hi; i++) l[i] = 1'b0;
        return l;
    endfunction

    task automatic capture(input logic [WIDTH-1:0] ln);
        line_i = ln;
        req_i  = 1'b1;
        step();
        check("ack", ack_o, 1);
        check("busy", busy_o, 1);
        req_i = 1'b0;
    endtask

    // Streams one line; pixel mismatches are reported individually.
    task automatic stream(input logic [WIDTH-1:0] ln, input int exp_start, input int exp_len,
                          input bit toggle, input bit disturb, input bit hold);
        int k = 0;
        int acks = 0;
        int done_cyc = -1;
        int pix_bad = 0;
        for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
            pix_en_i = toggle ? (cyc % 2 == 0) : 1'b1;
            req_i    = hold || (disturb && k >= 50 && k < 60);
            if (disturb && k == 50) line_i = ~ln;
            step();
            if (ack_o) acks++;
            if (pix_valid_o) begin
                if (pix_o !== ln[k] || col_o !== CW'(k)) begin
                    pix_bad++;
                    check("pixel", {pix_o, 21'b0, col_o}, {ln[k], 21'b0, CW'(k)});
                end
                k++;
            end
            if (done_o) begin
                done_cyc = cyc;
                check("done_col", col_o, WIDTH - 1);
                check("done_busy", busy_o, 0);
            end
        end
        pix_en_i = 1'b0;
        if (!hold) req_i = 1'b0;
        check("pix_errors", pix_bad, 0);
        check("pix_count", k, WIDTH);
        check("done_cycle", done_cyc, toggle ? 2 * WIDTH - 2 : WIDTH - 1);
        check("extra_ack", acks, 0);
        check("gap_start", gap_start_o, exp_start);
        check("gap_len", gap_len_o, exp_len);
    endtask

    logic [WIDTH-1:0] ones_l, l2, l3, l4, zero_l;
    int seen_done;

    initial begin
        ones_l = '1;
        zero_l = '0;
        l2 = zeros(300, 399, zeros(100, 149, ones_l));
        l3 = zeros(500, 509, zeros(10, 19, ones_l));
        l4 = zeros(630, 639, ones_l);

        reset_i = 1'b0; req_i = 1'b0; pix_en_i = 1'b0; line_i = '0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_valid", pix_valid_o, 0);
        check("rst_gaplen", gap_len_o, 0);
        reset_i = 1'b1;
        step();

        capture(ones_l);
        stream(ones_l, 0, 0, 0, 0, 0);
        capture(l2);
        stream(l2, 300, 100, 0, 0, 0);
        step();
        check("gap_hold", gap_len_o, 100);
        capture(l3);
        stream(l3, 10, 10, 0, 0, 0);
        capture(l4);
        stream(l4, 630, 10, 0, 0, 0);
        capture(zero_l);
        stream(zero_l, 0, 640, 0, 0, 0);
        capture(l2);
        stream(l2, 300, 100, 1, 0, 0);
        capture(l3);
        stream(l3, 10, 10, 0, 1, 0);

        // Async reset while streaming column 200.
        capture(l2);
        pix_en_i = 1'b1;
        for (int i = 0; i < 400 && !(pix_valid_o && col_o == 200); i++) step();
        check("pre_rst_col", col_o, 200);
        #2 reset_i = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_valid", pix_valid_o, 0);
        check("arst_pix", pix_o, 0);
        check("arst_col", col_o, 0);
        check("arst_gap", {gap_start_o, gap_len_o}, 0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_o) seen_done++;
        end
        check("arst_no_done", seen_done, 0);
        pix_en_i = 1'b0;
        @(negedge clk_i) reset_i = 1'b1;
        step();
        capture(l4);
        stream(l4, 630, 10, 0, 0, 0);

        // Back-to-back with req held: next line captured on the edge after done.
        capture(l3);
        req_i = 1'b1;
        stream(l3, 10, 10, 0, 0, 1);
        line_i = l2;
        step();
        check("b2b_ack", ack_o, 1);
        check("b2b_busy", busy_o, 1);
        req_i = 1'b0;
        stream(l2, 300, 100, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
